// File: rtl/serial_byte_loader_pkg.sv
// Shared definitions for the serial byte loader and its frame tracker.
// Loader states, frame length and default memory geometry.
package serial_byte_loader_pkg;

  localparam int WORD_COUNT_DEF = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int FRAME_LEN      = 8;
  localparam int BIT_W          = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT,
    DONE
  } loader_state_t;

endpackage

// File: rtl/serial_byte_loader_frame_tracker.sv
// Follows the circulating memory's bit frame and word rotation so writes can be
// aligned to the frame in which the target word sits in the write window.
module serial_frame_tracker
  import serial_byte_loader_pkg::*;
#(
  parameter int WORD_COUNT = WORD_COUNT_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic [ADDR_W-1:0] slot_ptr,
  output logic              frame_last,
  output logic [ADDR_W-1:0] next_slot
);

  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [ADDR_W-1:0] slot_ptr_reg;

  assign bit_cnt    = bit_cnt_reg;
  assign slot_ptr   = slot_ptr_reg;
  assign frame_last = (bit_cnt_reg == BIT_W'(FRAME_LEN - 1));
  assign next_slot  = (slot_ptr_reg == ADDR_W'(WORD_COUNT - 1)) ? '0
                                                                : slot_ptr_reg + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_reg  <= '0;
      slot_ptr_reg <= '0;
    end else begin
      bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
      if (frame_last) slot_ptr_reg <= next_slot;
    end
  end

endmodule

// File: rtl/serial_byte_loader.sv
// Feeds (address, byte) writes into the circulating serial memory, one full frame per request.
// Optional whole-memory fill is enabled with the SERIAL_LOADER_FILL_EN macro.
module serial_byte_loader
  import serial_byte_loader_pkg::*;
#(
  parameter int WORD_COUNT = WORD_COUNT_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
`ifdef SERIAL_LOADER_FILL_EN
  input  logic              fill_req,
`endif
  output logic              mem_write,
  output logic              mem_din,
  output logic              busy,
  output logic              done
);

  loader_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        data_reg, data_next;
  logic [BIT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] slot_ptr_unused;
  logic [ADDR_W-1:0] next_slot;
  logic              frame_last;
  logic              fill_start, fill_mode, fill_more;

  serial_frame_tracker #(
    .WORD_COUNT(WORD_COUNT),
    .ADDR_W    (ADDR_W)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .bit_cnt   (bit_cnt),
    .slot_ptr  (slot_ptr_unused),
    .frame_last(frame_last),
    .next_slot (next_slot)
  );

  // Out-of-range addresses only exist for non-power-of-two memories.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    if (int'(a) >= WORD_COUNT) return ADDR_W'(int'(a) - WORD_COUNT);
    return a;
  endfunction

`ifdef SERIAL_LOADER_FILL_EN
  logic              fill_reg;
  logic [ADDR_W-1:0] fill_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_reg     <= 1'b0;
      fill_cnt_reg <= '0;
    end else begin
      if (state_reg == IDLE) fill_reg <= fill_req;
      if (state_reg != SHIFT) fill_cnt_reg <= '0;
      else if (frame_last)   fill_cnt_reg <= fill_cnt_reg + ADDR_W'(1);
    end
  end

  assign fill_start = fill_req;
  assign fill_mode  = fill_reg;
  assign fill_more  = fill_reg && (fill_cnt_reg != ADDR_W'(WORD_COUNT - 1));
`else
  assign fill_start = 1'b0;
  assign fill_mode  = 1'b0;
  assign fill_more  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  // Outputs depend on registered state only, so the memory sees stable pins at its edge.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    wr_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    mem_write  = 1'b0;
    mem_din    = 1'b0;
    case (state_reg)
      IDLE: begin
        wr_ready = 1'b1;
        busy     = 1'b0;
        if (fill_start) begin
          data_next  = wr_data;
          state_next = WAIT;
        end else if (wr_valid) begin
          addr_next  = wrap_addr(wr_addr);
          data_next  = wr_data;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (frame_last && (fill_mode || next_slot == addr_reg)) state_next = SHIFT;
      end
      SHIFT: begin
        mem_write = 1'b1;
        mem_din   = data_reg[bit_cnt];
        if (frame_last && !fill_more) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Self-checking bench for serial_byte_loader with a behavioural circulating memory model.
// Define SERIAL_LOADER_FILL_EN to also exercise the fill feature.
module tb_serial_byte_loader;
  import serial_byte_loader_pkg::*;

  localparam int WC = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          wr_ready, mem_write, mem_din, busy, done;
`ifdef SERIAL_LOADER_FILL_EN
  logic          fill_req = 1'b0;
`endif

  always #5 clk = ~clk;

  serial_byte_loader #(.WORD_COUNT(WC), .ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`ifdef SERIAL_LOADER_FILL_EN
    .fill_req (fill_req),
`endif
    .mem_write(mem_write),
    .mem_din  (mem_din),
    .busy     (busy),
    .done     (done)
  );

  // Memory model: its own frame tracker, reset together with the loader.
  logic [2:0]    mt_bit;
  logic [AW-1:0] mt_slot, mt_next;
  logic          mt_last;

  serial_frame_tracker #(.WORD_COUNT(WC), .ADDR_W(AW)) u_mem_trk (
    .clk       (clk),
    .reset     (reset),
    .bit_cnt   (mt_bit),
    .slot_ptr  (mt_slot),
    .frame_last(mt_last),
    .next_slot (mt_next)
  );

  logic [7:0] mem [WC];
  logic       mem_init = 1'b0;
  logic       rst_q = 1'b1;
  int         cyc = 0;

  always @(posedge clk) begin
    rst_q <= reset;
    cyc   <= reset ? 0 : cyc + 1;
    if (!mem_init) begin
      for (int i = 0; i < WC; i++) mem[i] <= 8'(i * 37 + 11);
      mem_init <= 1'b1;
    end else if (!reset && mem_write) begin
      mem[mt_slot][mt_bit] <= mem_din;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    bit            fill;
  } sb_t;
  sb_t sb[$];

  // Monitor: reassembles each driven frame and retires scoreboard entries on done.
  logic [7:0]    fbyte = '0;
  logic [AW-1:0] fslot = '0;
  int            nbits = 0, frames = 0, done_cnt = 0, align_err = 0, mon_bad = 0;
  sb_t           e;

  always @(negedge clk) begin
    if (mt_bit != 3'(cyc % 8) || mt_slot != AW'((cyc / 8) % WC) ||
        mt_last != (mt_bit == 3'd7) || mt_next != AW'((int'(mt_slot) + 1) % WC))
      align_err++;
    if (rst_q) begin
      nbits  = 0;
      frames = 0;
    end else begin
      if (mem_write) begin
        if (nbits == 0) begin
          check("frame_align", 32'(mt_bit), 0);
          fslot = mt_slot;
        end
        fbyte[mt_bit] = mem_din;
        nbits++;
        if (nbits == 8) begin
          if (sb.size() == 0) check("write_has_request", 0, 1);
          else begin
            check("frame_byte", 32'(fbyte), 32'(sb[0].data));
            if (!sb[0].fill) check("frame_slot", 32'(fslot), 32'(sb[0].addr));
          end
          frames++;
          nbits = 0;
        end
      end else if (nbits != 0) begin
        check("frame_complete", nbits, 8);
        nbits = 0;
      end
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) check("done_has_request", 0, 1);
        else begin
          e = sb.pop_front();
          if (e.fill) begin
            mon_bad = 0;
            for (int i = 0; i < WC; i++) if (mem[i] !== e.data) mon_bad++;
            check("fill_frames", frames, WC);
            check("fill_all_slots", mon_bad, 0);
            $display("txn fill data=%02h frames=%0d bad_slots=%0d", e.data, frames, mon_bad);
          end else begin
            check("frames_per_req", frames, 1);
            check("readback", 32'(mem[e.addr]), 32'(e.data));
            $display("txn write addr=%0d data=%02h readback=%02h", e.addr, e.data, mem[e.addr]);
          end
        end
        frames = 0;
      end
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [7:0] d);
    int  t = 0;
    sb_t s;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("accept_in_time", 32'(t < 1000), 1);
    s.addr = a;
    s.data = d;
    s.fill = 1'b0;
    sb.push_back(s);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((sb.size() != 0 || !wr_ready) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_in_time", 32'(t < budget), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [7:0]    exp;
  } vec_t;
  vec_t vecs[4];

  logic [7:0]    snap [WC];
  logic [7:0]    expv;
  logic [AW-1:0] s0;
  int            idle_bad, s255, s256, lat, d0, others_bad, run;

  initial begin
    vecs[0] = '{addr: 5'd31, data: 8'h3C, exp: 8'h3C};
    vecs[1] = '{addr: 5'd1,  data: 8'hFF, exp: 8'hFF};
    vecs[2] = '{addr: 5'd9,  data: 8'h00, exp: 8'h00};
    vecs[3] = '{addr: 5'd20, data: 8'h5A, exp: 8'h5A};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_din", 32'(mem_din), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b0;

    // Idle for 300 cycles: quiet pins, slot pointer wraps at cycle 256
    idle_bad = 0; s255 = -1; s256 = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_write !== 1'b0 || mem_din !== 1'b0 || done !== 1'b0) idle_bad++;
      if (cyc == 255) s255 = int'(mt_slot);
      if (cyc == 256) s256 = int'(mt_slot);
    end
    check("idle_quiet", idle_bad, 0);
    check("slot_at_255", s255, 31);
    check("slot_at_256", s256, 0);

    // addr 0 at cycle 2 after reset: slot 0 is in the window, so SHIFT begins at cycle 256
    do_reset();
    lat = 0;
    while (cyc != 2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    send(5'd0, 8'hA5);
    lat = 0;
    while (!mem_write && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("a5_shift_start_cyc", cyc, 256);
    check("busy_in_shift", 32'(busy), 1);
    check("ready_low_in_shift", 32'(wr_ready), 0);
    wait_idle(50);

    // Table: back-to-back requests; ready must stay low until the first completes
    for (int i = 0; i < WC; i++) snap[i] = mem[i];
    d0 = done_cnt;
    send(vecs[0].addr, vecs[0].data);
    send(vecs[1].addr, vecs[1].data);
    check("ready_held_until_done", done_cnt - d0, 1);
    for (int i = 2; i < 4; i++) send(vecs[i].addr, vecs[i].data);
    wait_idle(600);
    others_bad = 0;
    for (int i = 0; i < WC; i++) begin
      expv = snap[i];
      for (int v = 0; v < 4; v++) if (int'(vecs[v].addr) == i) expv = vecs[v].exp;
      if (mem[i] !== expv) others_bad++;
    end
    for (int v = 0; v < 4; v++) check("table_slot", 32'(mem[vecs[v].addr]), 32'(vecs[v].exp));
    check("table_slots_changed", others_bad, 0);

    // Request for the slot currently in the window at bit 3: full revolution wait
    lat = 0;
    while (mt_bit != 3'd3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s0 = mt_slot;
    send(s0, 8'h6E);
    lat = 1;
    while (!mem_write && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("window_wait_cycles", lat, 253);
    check("window_slot", 32'(mt_slot), 32'(s0));
    wait_idle(50);

    // Reset during SHIFT at bit 4: abort, no done pulse, then a clean write
    send(5'd12, 8'hC3);
    lat = 0;
    while (!(mem_write && mt_bit == 3'd4) && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    check("reached_bit4", 32'(lat < 600), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_write", 32'(mem_write), 0);
    check("abort_done", 32'(done), 0);
    check("abort_wr_ready", 32'(wr_ready), 1);
    check("abort_busy", 32'(busy), 0);
    sb.delete();
    reset = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", done_cnt - d0, 0);
    send(5'd12, 8'h96);
    wait_idle(600);
    check("post_abort_slot", 32'(mem[12]), 32'h96);

`ifdef SERIAL_LOADER_FILL_EN
    // Fill every slot with 0x81
    begin
      sb_t f;
      f.addr = '0;
      f.data = 8'h81;
      f.fill = 1'b1;
      fill_req = 1'b1;
      wr_data  = 8'h81;
      sb.push_back(f);
      @(negedge clk);
      fill_req = 1'b0;
      d0  = done_cnt;
      lat = 0;
      while (!mem_write && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      run = 0;
      while (mem_write && run < 400) begin
        run++;
        @(negedge clk);
      end
      check("fill_run", run, 256);
      check("fill_done_pulse", 32'(done), 1);
      @(negedge clk);
      check("fill_done_single", 32'(done), 0);
      check("fill_done_count", done_cnt - d0, 1);
      wait_idle(20);
    end
`endif

    check("tracker_alignment", align_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
